// File: rtl/ifu_prefetch.sv
// rtl/ifu_prefetch.sv - instruction prefetch unit with epoch-tagged AXI-Lite reads and a FWFT fetch FIFO
module ifu_prefetch #(
  parameter logic [31:0] RESET_PC        = 32'h3000_0000,
  parameter int          FIFO_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter int          EPOCH_W         = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        exc_valid,
  input  logic [31:0] csr_mtvec,
  input  logic        fence_i,
  input  logic [31:0] fence_pc,
  input  logic        icache_flush_done,
  output logic [31:0] axi_araddr,
  output logic        axi_arvalid,
  input  logic        axi_arready,
  input  logic        axi_rvalid,
  output logic        axi_rready,
  input  logic [31:0] axi_rdata,
  input  logic [1:0]  axi_rresp,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_fault
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FENCE = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [31:0]        fetch_pc;
  logic [31:0]        pend_pc;
  logic               pend_valid;
  logic [EPOCH_W-1:0] cur_epoch;
  logic [EPOCH_W-1:0] ar_epoch;
  logic               arvalid_q;
  logic [OW-1:0]      outstanding;

  logic [EPOCH_W-1:0] tag_epoch [MAX_OUTSTANDING];
  logic [31:0]        tag_pc    [MAX_OUTSTANDING];
  logic [TW-1:0]      tag_wr, tag_rd;

  logic [31:0]        fifo_pc    [FIFO_DEPTH];
  logic [31:0]        fifo_inst  [FIFO_DEPTH];
  logic               fifo_fault [FIFO_DEPTH];
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      count;

  logic        flush;
  logic [31:0] flush_pc;
  logic        ar_hs, r_hs, credit, issue, push, pop;

  assign flush    = exc_valid | redirect_valid | fence_i;
  assign flush_pc = exc_valid ? csr_mtvec : (redirect_valid ? redirect_pc : fence_pc);

  assign ar_hs  = arvalid_q & axi_arready;
  assign r_hs   = axi_rvalid & axi_rready;
  assign credit = (state == ST_RUN) && (32'(outstanding) < MAX_OUTSTANDING) &&
                  ((32'(count) + 32'(outstanding)) < FIFO_DEPTH);
  // A flush cycle never starts a request so the new target and epoch take effect first.
  assign issue  = credit & ~arvalid_q & ~flush;
  assign push   = r_hs && (tag_epoch[tag_rd] == cur_epoch) && !flush;
  assign pop    = out_valid & out_ready & ~flush;

  assign axi_araddr  = fetch_pc;
  assign axi_arvalid = arvalid_q;
  assign axi_rready  = (outstanding != '0);

  assign out_valid = (count != '0);
  assign out_pc    = out_valid ? fifo_pc[rd_ptr]   : 32'd0;
  assign out_inst  = out_valid ? fifo_inst[rd_ptr] : 32'd0;
  assign out_fault = out_valid ? fifo_fault[rd_ptr] : 1'b0;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:   if (fence_i && !exc_valid && !redirect_valid) state_nxt = ST_FENCE;
      ST_FENCE: if (icache_flush_done && (outstanding == '0)) state_nxt = ST_RUN;
      default:  state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_RUN;
      fetch_pc    <= RESET_PC;
      pend_pc     <= 32'd0;
      pend_valid  <= 1'b0;
      cur_epoch   <= '0;
      ar_epoch    <= '0;
      arvalid_q   <= 1'b0;
      outstanding <= '0;
      tag_wr      <= '0;
      tag_rd      <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
    end else begin
      state <= state_nxt;
      if (flush) cur_epoch <= cur_epoch + 1'b1;

      // A pending AR keeps its address; the redirect target is parked until the handshake.
      if (ar_hs) begin
        arvalid_q  <= 1'b0;
        pend_valid <= 1'b0;
        if (flush)           fetch_pc <= flush_pc;
        else if (pend_valid) fetch_pc <= pend_pc;
        else                 fetch_pc <= fetch_pc + 32'd4;
      end else begin
        if (issue) begin
          arvalid_q <= 1'b1;
          ar_epoch  <= cur_epoch;
        end
        if (flush) begin
          if (arvalid_q) begin
            pend_valid <= 1'b1;
            pend_pc    <= flush_pc;
          end else begin
            fetch_pc <= flush_pc;
          end
        end
      end

      if (ar_hs) tag_wr <= (tag_wr == TW'(MAX_OUTSTANDING - 1)) ? '0 : tag_wr + 1'b1;
      if (r_hs)  tag_rd <= (tag_rd == TW'(MAX_OUTSTANDING - 1)) ? '0 : tag_rd + 1'b1;
      if (ar_hs && !r_hs)      outstanding <= outstanding + 1'b1;
      else if (!ar_hs && r_hs) outstanding <= outstanding - 1'b1;

      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      count <= count + 1'b1;
        else if (!push && pop) count <= count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ar_hs) begin
      tag_epoch[tag_wr] <= ar_epoch;
      tag_pc[tag_wr]    <= fetch_pc;
    end
    if (push) begin
      fifo_pc[wr_ptr]    <= tag_pc[tag_rd];
      fifo_inst[wr_ptr]  <= axi_rdata;
      fifo_fault[wr_ptr] <= (axi_rresp != 2'b00);
    end
  end

endmodule
